// File: rtl/systolic_feed_ctrl.sv
// Sequencer and access arbiter for the four operand RAMs feeding the 2x2 systolic array.
// IDLE passes host preload writes through; a start streams K words per lane, lane 1 one cycle behind lane 0.
module systolic_feed_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   k_len,
  output logic              busy,
  output logic              done,
  input  logic              host_we,
  input  logic [1:0]        host_sel,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_di,
  output logic              host_rdy,
  output logic [3:0]        ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr0,
  output logic [ADDR_W-1:0] ram_addr1,
  output logic [DATA_W-1:0] ram_di,
  output logic              pe_clr,
  output logic              feed_vld0,
  output logic              feed_vld1
);

  localparam int CW = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] c0;
  logic [CW-1:0] c1;
  logic [CW-1:0] k;
  logic          k_ok;
  logic          lane0;
  logic          lane1;
  logic          host_wr;

  // c0 counts RUN cycles 0..K; lane 1 starts once c0 has left 0, giving the one-cycle skew.
  always_comb begin
    k_ok    = (k_len != '0) && (k_len <= CW'(DEPTH));
    lane0   = (state == RUN) && (c0 < k);
    lane1   = (state == RUN) && (c0 != '0) && (c1 < k);
    host_wr = (state == IDLE) && host_we;
  end

  always_comb begin
    ram_en    = '0;
    ram_we    = '0;
    ram_addr0 = '0;
    ram_addr1 = '0;
    ram_di    = '0;
    if (rst_n) begin
      if (host_wr) begin
        ram_en[host_sel] = 1'b1;
        ram_we[host_sel] = 1'b1;
        ram_di           = host_di;
        if (host_sel[0]) ram_addr1 = host_addr;
        else             ram_addr0 = host_addr;
      end
      if (lane0) begin
        ram_en[0] = 1'b1;
        ram_en[2] = 1'b1;
        ram_addr0 = c0[ADDR_W-1:0];
      end
      if (lane1) begin
        ram_en[1] = 1'b1;
        ram_en[3] = 1'b1;
        ram_addr1 = c1[ADDR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      c0        <= '0;
      c1        <= '0;
      k         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pe_clr    <= 1'b0;
      feed_vld0 <= 1'b0;
      feed_vld1 <= 1'b0;
      host_rdy  <= 1'b1;
    end else begin
      done      <= 1'b0;
      pe_clr    <= 1'b0;
      feed_vld0 <= lane0;
      feed_vld1 <= lane1;
      case (state)
        IDLE: begin
          if (start) begin
            k        <= k_len;
            c0       <= '0;
            c1       <= '0;
            busy     <= 1'b1;
            host_rdy <= 1'b0;
            if (k_ok) begin
              state  <= RUN;
              pe_clr <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (lane0) c0 <= c0 + 1'b1;
          if (lane1) c1 <= c1 + 1'b1;
          // c0 parks at K while lane 1 issues its last read.
          if (c0 == k) begin
            state <= DRAIN;
            c0    <= '0;
          end
        end
        DRAIN: begin
          if (c0 == CW'(1)) begin
            state <= DONE;
            done  <= 1'b1;
            c0    <= '0;
          end else begin
            c0 <= c0 + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          busy     <= 1'b0;
          host_rdy <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed bench for systolic_feed_ctrl: reset, preload pass-through, K runs, invalid K,
// ignored inputs during a run and reset in the middle of a run.
module tb_systolic_feed_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  k_len;
  logic        busy;
  logic        done;
  logic        host_we;
  logic [1:0]  host_sel;
  logic [3:0]  host_addr;
  logic [15:0] host_di;
  logic        host_rdy;
  logic [3:0]  ram_en;
  logic [3:0]  ram_we;
  logic [3:0]  ram_addr0;
  logic [3:0]  ram_addr1;
  logic [15:0] ram_di;
  logic        pe_clr;
  logic        feed_vld0;
  logic        feed_vld1;

  int n_vec = 0;
  int n_err = 0;

  systolic_feed_ctrl #(.ADDR_W(4), .DATA_W(16), .DEPTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .k_len     (k_len),
    .busy      (busy),
    .done      (done),
    .host_we   (host_we),
    .host_sel  (host_sel),
    .host_addr (host_addr),
    .host_di   (host_di),
    .host_rdy  (host_rdy),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr0 (ram_addr0),
    .ram_addr1 (ram_addr1),
    .ram_di    (ram_di),
    .pe_clr    (pe_clr),
    .feed_vld0 (feed_vld0),
    .feed_vld1 (feed_vld1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Walks one start from acceptance (t=0) back to IDLE, checking every output against the timing table.
  // At t == inj_t, start and host_we are raised again and must be ignored.
  task automatic run_k(input int kv, input int inj_t);
    bit vk;
    int last;
    bit e_busy, e_done, e_clr, l0, l1, v0, v1;
    logic [3:0] e_en;
    int a0, a1;
    string p;
    vk   = (kv >= 1) && (kv <= 16);
    last = vk ? kv + 5 : 2;
    for (int t = 0; t <= last; t++) begin
      start     = (t == 0) || (t == inj_t);
      k_len     = (t == 0) ? kv[4:0] : 5'd0;
      host_we   = (t == inj_t);
      host_sel  = 2'd0;
      host_addr = 4'd7;
      host_di   = 16'hBEEF;
      @(negedge clk);
      if (vk) begin
        e_busy = (t >= 1) && (t <= kv + 4);
        e_done = (t == kv + 4);
        e_clr  = (t == 1);
        l0     = (t >= 1) && (t <= kv);
        l1     = (t >= 2) && (t <= kv + 1);
        v0     = (t >= 2) && (t <= kv + 1);
        v1     = (t >= 3) && (t <= kv + 2);
      end else begin
        e_busy = (t == 1);
        e_done = (t == 1);
        e_clr  = 1'b0;
        l0     = 1'b0;
        l1     = 1'b0;
        v0     = 1'b0;
        v1     = 1'b0;
      end
      e_en = {l1, l0, l1, l0};
      a0   = l0 ? t - 1 : 0;
      a1   = l1 ? t - 2 : 0;
      p    = $sformatf("k%0d t%0d", kv, t);
      check({p, " busy"},   32'(busy),      32'(e_busy));
      check({p, " done"},   32'(done),      32'(e_done));
      check({p, " pe_clr"}, 32'(pe_clr),    32'(e_clr));
      check({p, " ram_en"}, 32'(ram_en),    32'(e_en));
      check({p, " ram_we"}, 32'(ram_we),    32'd0);
      check({p, " addr0"},  32'(ram_addr0), 32'(a0));
      check({p, " addr1"},  32'(ram_addr1), 32'(a1));
      check({p, " vld0"},   32'(feed_vld0), 32'(v0));
      check({p, " vld1"},   32'(feed_vld1), 32'(v1));
      check({p, " rdy"},    32'(host_rdy),  32'(!e_busy));
      next_cycle();
    end
    start   = 1'b0;
    host_we = 1'b0;
  endtask

  task automatic host_write(input logic [1:0] sel, input logic [3:0] addr, input logic [15:0] di,
                            input logic [3:0] e_en, input logic [3:0] e_a0, input logic [3:0] e_a1);
    host_we   = 1'b1;
    host_sel  = sel;
    host_addr = addr;
    host_di   = di;
    @(negedge clk);
    check($sformatf("wr%0d ram_en", sel), 32'(ram_en),    32'(e_en));
    check($sformatf("wr%0d ram_we", sel), 32'(ram_we),    32'(e_en));
    check($sformatf("wr%0d addr0", sel),  32'(ram_addr0), 32'(e_a0));
    check($sformatf("wr%0d addr1", sel),  32'(ram_addr1), 32'(e_a1));
    check($sformatf("wr%0d di", sel),     32'(ram_di),    32'(di));
    next_cycle();
    host_we = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    k_len     = 5'd0;
    host_we   = 1'b0;
    host_sel  = 2'd0;
    host_addr = 4'd0;
    host_di   = 16'd0;

    repeat (3) next_cycle();
    @(negedge clk);
    check("rst busy",   32'(busy),      32'd0);
    check("rst done",   32'(done),      32'd0);
    check("rst pe_clr", 32'(pe_clr),    32'd0);
    check("rst vld0",   32'(feed_vld0), 32'd0);
    check("rst vld1",   32'(feed_vld1), 32'd0);
    check("rst ram_en", 32'(ram_en),    32'd0);
    check("rst rdy",    32'(host_rdy),  32'd1);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    host_write(2'd3, 4'd5, 16'h0009, 4'b1000, 4'd0, 4'd5);
    host_write(2'd0, 4'd2, 16'h1234, 4'b0001, 4'd2, 4'd0);
    host_write(2'd2, 4'd15, 16'hA5A5, 4'b0100, 4'd15, 4'd0);

    run_k(3, 4);
    run_k(16, -1);
    run_k(1, -1);
    run_k(0, -1);
    run_k(17, -1);

    // Reset lands in S+2 of a K=3 run.
    for (int t = 0; t <= 6; t++) begin
      start = (t == 0);
      k_len = 5'd3;
      rst_n = (t != 2);
      @(negedge clk);
      if (t == 2) check("midrst en t2", 32'(ram_en), 32'd0);
      if (t >= 3) begin
        check($sformatf("midrst t%0d busy", t), 32'(busy),      32'd0);
        check($sformatf("midrst t%0d done", t), 32'(done),      32'd0);
        check($sformatf("midrst t%0d rdy", t),  32'(host_rdy),  32'd1);
        check($sformatf("midrst t%0d en", t),   32'(ram_en),    32'd0);
        check($sformatf("midrst t%0d vld", t),  32'({feed_vld1, feed_vld0}), 32'd0);
      end
      next_cycle();
    end
    start = 1'b0;
    rst_n = 1'b1;

    run_k(2, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
